// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } bcd_state_t;

  localparam int          N_DIGITS = 4;
  localparam int          BCD_MAX  = 9999;
  localparam logic [15:0] ERR_WORD = 16'hEEEE;
  localparam logic [15:0] SAT_WORD = 16'h9999;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble correction: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Define BCD_SATURATE_EN to show 9999 on overflow instead of the EEEE error word.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd,
  output logic             overflow
);

  localparam int SR_W  = 16 + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);

`ifdef BCD_SATURATE_EN
  localparam logic [15:0] OVF_WORD = SAT_WORD;
`else
  localparam logic [15:0] OVF_WORD = ERR_WORD;
`endif

  bcd_state_t       state;
  logic [SR_W-1:0]  sr;
  logic [CNT_W-1:0] cnt;
  logic             ovf_pend;
  logic [15:0]      adj;
  logic [SR_W-1:0]  sr_next;

  // Correct every digit first, then shift the whole register one place left.
  for (genvar d = 0; d < N_DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (sr[BIN_W + 4*d +: 4]),
      .dout (adj[4*d +: 4])
    );
  end

  assign sr_next = {adj[14:0], sr[BIN_W-1:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= 16'h0000;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr       <= {16'h0000, bin};
            cnt      <= '0;
            ovf_pend <= (32'(bin) > BCD_MAX);
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= sr_next;
          cnt <= cnt + CNT_W'(1);
          // The output word is only touched here, so the display never sees partial digits.
          if (cnt == CNT_W'(BIN_W - 1)) begin
            bcd      <= ovf_pend ? OVF_WORD : sr_next[SR_W-1 -: 16];
            overflow <= ovf_pend;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
